// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer: computes an n-bit add (sum, carry-out, group propagate/generate)
// by iterating a shared w-bit adder slice over n/w chunks, LSB chunk first.
// Optional macro ADDSEQ_SELFCHECK_EN adds a full-width self-check that drives err.
module adder_slice_sequencer #(
  parameter int unsigned n = 256,
  parameter int unsigned w = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         cin,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] s,
  output logic         cout,
  output logic         prop,
  output logic         gen,
  output logic         busy,
  output logic         err
);

  localparam int unsigned K  = n / w;
  localparam int unsigned IW = (K > 1) ? $clog2(K) : 1;
  localparam int unsigned SW = (n > 1) ? $clog2(n) : 1;
  localparam int unsigned W1 = w + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [IW-1:0] idx;
  logic [n-1:0]  a_q, b_q;
  logic [SW-1:0] base;
  logic [w-1:0]  a_chunk, b_chunk, gsum;
  logic [W1-1:0] sum;
  logic          p_w, g_w, last;

  // Shared slice: current chunk sum with registered carry, plus chunk propagate/generate.
  // cout doubles as the inter-chunk carry register, prop/gen as the group accumulators.
  always_comb begin
    base    = SW'(idx) * SW'(w);
    a_chunk = a_q[base +: w];
    b_chunk = b_q[base +: w];
    sum     = W1'(a_chunk) + W1'(b_chunk) + W1'(cout);
    gsum    = a_chunk + b_chunk;
    g_w     = (gsum < a_chunk);
    p_w     = &(a_chunk ^ b_chunk);
    last    = (idx == IW'(K - 1));
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register and registered handshake/status outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d == RUN);
    end
  end

  // Operand capture and per-chunk datapath updates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      idx  <= '0;
      s    <= '0;
      cout <= 1'b0;
      prop <= 1'b0;
      gen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            cout <= cin;
            prop <= 1'b1;
            gen  <= 1'b0;
            idx  <= '0;
          end
        end
        RUN: begin
          s[base +: w] <= sum[w-1:0];
          cout         <= sum[w];
          gen          <= g_w | (p_w & gen);
          prop         <= prop & p_w;
          idx          <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef ADDSEQ_SELFCHECK_EN
  localparam int unsigned N1 = n + 1;

  logic          cin_q;
  logic [N1-1:0] ref_sum;
  logic [n-1:0]  ref_gsum;
  logic          mism;

  // Carry-in is only needed again for the full-width comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cin_q <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      cin_q <= cin;
    end
  end

  // Full-width reference for the held result; outputs are stable throughout DONE.
  always_comb begin
    ref_sum  = N1'(a_q) + N1'(b_q) + N1'(cin_q);
    ref_gsum = a_q + b_q;
    mism     = (state == DONE) &&
               (({cout, s} != ref_sum) || (prop != &(a_q ^ b_q)) || (gen != (ref_gsum < a_q)));
  end

  // Sticky mismatch flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (mism) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
